// File: rtl/srm_controller.sv
// ---------------------------------------------------------------------------
// srm_controller
//
// Control FSM for a simple register machine datapath. A start request in WAIT
// captures the instruction fields (opcode/op/sh). The FSM then walks the
// register-read, compute and writeback steps for that instruction and drives
// the datapath control strobes.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   s                     start request (only honoured in WAIT)
//   opcode[2:0], op[1:0]  instruction class / operation
//   sh[1:0]               shifter field
//   w                     ready (high only in WAIT)
//   nsel[2:0]             one-hot register select: 001 Rn, 010 Rd, 100 Rm
//   vsel[1:0]             writeback source: 00 datapath C, 10 sign-ext imm8
//   loada/loadb/loadc/loads  datapath register load enables
//   asel, bsel            ALU operand muxes (asel zeroes A, bsel unused = 0)
//   shift[1:0], ALUop[1:0]   shifter / ALU operation codes
//   write                 register file write enable
//   err                   one-cycle pulse when an illegal instruction decodes
//
// All outputs are registered. They are computed from the next state and the
// next latched fields, so each output register always matches the state
// register and never depends combinationally on the raw inputs.
// ---------------------------------------------------------------------------
module srm_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [1:0] sh,
    output logic       w,
    output logic [2:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] shift,
    output logic [1:0] ALUop,
    output logic       write,
    output logic       err
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WRITE_REG,
        S_WRITE_IMM
    } state_t;

    typedef enum logic [2:0] {
        I_MOVI,
        I_MOVR,
        I_MVN,
        I_ADD,
        I_CMP,
        I_AND,
        I_ILL
    } instr_t;

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       write;
        logic       err;
    } ctrl_t;

    state_t     state, state_nxt;
    logic [2:0] opcode_q, opcode_nxt;
    logic [1:0] op_q, op_nxt;
    logic [1:0] sh_q, sh_nxt;
    ctrl_t      ctrl_q, ctrl_nxt;

    function automatic instr_t classify(input logic [2:0] opc, input logic [1:0] opv);
        instr_t k;
        case ({opc, opv})
            5'b110_10: k = I_MOVI;
            5'b110_00: k = I_MOVR;
            5'b101_11: k = I_MVN;
            5'b101_00: k = I_ADD;
            5'b101_01: k = I_CMP;
            5'b101_10: k = I_AND;
            default:   k = I_ILL;
        endcase
        return k;
    endfunction

    // Moore output decode: state plus latched instruction fields only.
    function automatic ctrl_t ctrl_for(input state_t st, input logic [2:0] opc,
                                       input logic [1:0] opv, input logic [1:0] shv);
        ctrl_t  c;
        instr_t k;
        c = '0;
        k = classify(opc, opv);
        case (st)
            S_WAIT:   c.w = 1'b1;
            S_DECODE: c.err = (k == I_ILL);
            S_GET_A: begin
                c.nsel  = 3'b001;
                c.loada = 1'b1;
            end
            S_GET_B: begin
                c.nsel  = 3'b100;
                c.loadb = 1'b1;
            end
            S_COMPUTE: begin
                c.shift = shv;
                // MOV reg passes B through an add with A forced to zero.
                c.aluop = (k == I_MOVR) ? 2'b00 : opv;
                c.asel  = (k == I_MOVR);
                c.loadc = (k != I_CMP);
                c.loads = (k == I_CMP);
            end
            S_WRITE_REG: begin
                c.nsel  = 3'b010;
                c.vsel  = 2'b00;
                c.write = 1'b1;
            end
            S_WRITE_IMM: begin
                c.nsel  = 3'b001;
                c.vsel  = 2'b10;
                c.write = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_nxt  = state;
        opcode_nxt = opcode_q;
        op_nxt     = op_q;
        sh_nxt     = sh_q;
        case (state)
            S_WAIT: begin
                if (s) begin
                    opcode_nxt = opcode;
                    op_nxt     = op;
                    sh_nxt     = sh;
                    state_nxt  = S_DECODE;
                end
            end
            S_DECODE: begin
                case (classify(opcode_q, op_q))
                    I_MOVI:               state_nxt = S_WRITE_IMM;
                    I_MOVR, I_MVN:        state_nxt = S_GET_B;
                    I_ADD, I_CMP, I_AND:  state_nxt = S_GET_A;
                    default:              state_nxt = S_WAIT;
                endcase
            end
            S_GET_A:   state_nxt = S_GET_B;
            S_GET_B:   state_nxt = S_COMPUTE;
            S_COMPUTE: state_nxt = (classify(opcode_q, op_q) == I_CMP) ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG, S_WRITE_IMM: state_nxt = S_WAIT;
            default:   state_nxt = S_WAIT;
        endcase
        ctrl_nxt = ctrl_for(state_nxt, opcode_nxt, op_nxt, sh_nxt);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= S_WAIT;
            opcode_q <= 3'b000;
            op_q     <= 2'b00;
            sh_q     <= 2'b00;
            ctrl_q   <= ctrl_for(S_WAIT, 3'b000, 2'b00, 2'b00);
        end else begin
            state    <= state_nxt;
            opcode_q <= opcode_nxt;
            op_q     <= op_nxt;
            sh_q     <= sh_nxt;
            ctrl_q   <= ctrl_nxt;
        end
    end

    assign w     = ctrl_q.w;
    assign nsel  = ctrl_q.nsel;
    assign vsel  = ctrl_q.vsel;
    assign loada = ctrl_q.loada;
    assign loadb = ctrl_q.loadb;
    assign loadc = ctrl_q.loadc;
    assign loads = ctrl_q.loads;
    assign asel  = ctrl_q.asel;
    assign bsel  = ctrl_q.bsel;
    assign shift = ctrl_q.shift;
    assign ALUop = ctrl_q.aluop;
    assign write = ctrl_q.write;
    assign err   = ctrl_q.err;

endmodule

// File: tb/tb_srm_controller.sv
// ---------------------------------------------------------------------------
// tb_srm_controller
//
// Directed and randomized bench for srm_controller. A reference model builds,
// per instruction, the list of control vectors expected on each cycle after
// the start request is accepted, plus the ready latency, straight from the
// instruction path rules.
// ---------------------------------------------------------------------------
module tb_srm_controller;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       s;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] sh;
    logic       w;
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] shift;
    logic [1:0] ALUop;
    logic       write, err;

    always #5 clk = ~clk;

    srm_controller dut (
        .clk    (clk),
        .reset_n(reset_n),
        .s      (s),
        .opcode (opcode),
        .op     (op),
        .sh     (sh),
        .w      (w),
        .nsel   (nsel),
        .vsel   (vsel),
        .loada  (loada),
        .loadb  (loadb),
        .loadc  (loadc),
        .loads  (loads),
        .asel   (asel),
        .bsel   (bsel),
        .shift  (shift),
        .ALUop  (ALUop),
        .write  (write),
        .err    (err)
    );

    typedef struct packed {
        logic       w;
        logic [2:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       write;
        logic       err;
    } vec_t;

    localparam int K_MOVI = 0;
    localparam int K_MOVR = 1;
    localparam int K_MVN  = 2;
    localparam int K_ADD  = 3;
    localparam int K_CMP  = 4;
    localparam int K_AND  = 5;
    localparam int K_ILL  = 6;

    vec_t cur;
    assign cur = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, shift, ALUop, write, err};

    int   checks = 0;
    int   fails  = 0;
    vec_t exp_q[$];
    vec_t idle_v;

    function automatic int kind_of(input logic [2:0] opc, input logic [1:0] opv);
        if (opc == 3'b110 && opv == 2'b10) return K_MOVI;
        if (opc == 3'b110 && opv == 2'b00) return K_MOVR;
        if (opc == 3'b101 && opv == 2'b11) return K_MVN;
        if (opc == 3'b101 && opv == 2'b00) return K_ADD;
        if (opc == 3'b101 && opv == 2'b01) return K_CMP;
        if (opc == 3'b101 && opv == 2'b10) return K_AND;
        return K_ILL;
    endfunction

    function automatic int lat_of(input int k);
        case (k)
            K_MOVI:        return 3;
            K_CMP:         return 5;
            K_MOVR, K_MVN: return 5;
            K_ADD, K_AND:  return 6;
            default:       return 2;
        endcase
    endfunction

    // Expected control vectors for the cycles between acceptance and ready.
    task automatic build_expect(input int k, input logic [1:0] opv, input logic [1:0] shv);
        vec_t v;
        exp_q.delete();
        v = '0;
        v.err = (k == K_ILL);
        exp_q.push_back(v);
        if (k == K_ILL) return;
        if (k == K_MOVI) begin
            v = '0; v.nsel = 3'b001; v.vsel = 2'b10; v.write = 1'b1;
            exp_q.push_back(v);
            return;
        end
        if (k == K_ADD || k == K_CMP || k == K_AND) begin
            v = '0; v.nsel = 3'b001; v.loada = 1'b1;
            exp_q.push_back(v);
        end
        v = '0; v.nsel = 3'b100; v.loadb = 1'b1;
        exp_q.push_back(v);
        v = '0;
        v.shift = shv;
        v.aluop = (k == K_MOVR) ? 2'b00 : opv;
        v.asel  = (k == K_MOVR);
        v.loadc = (k != K_CMP);
        v.loads = (k == K_CMP);
        exp_q.push_back(v);
        if (k != K_CMP) begin
            v = '0; v.nsel = 3'b010; v.vsel = 2'b00; v.write = 1'b1;
            exp_q.push_back(v);
        end
    endtask

    task automatic chk(input string tag, input vec_t o, input vec_t e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk_int(input string tag, input int o, input int e);
        checks++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction on the current (WAIT) cycle and follow it to ready,
    // scrambling s and the instruction inputs while the block is busy.
    task automatic run_instr(input logic [2:0] opc, input logic [1:0] opv,
                             input logic [1:0] shv, input string tag);
        int k;
        int n;
        k = kind_of(opc, opv);
        build_expect(k, opv, shv);
        chk({tag, " ready"}, cur, idle_v);
        s = 1'b1; opcode = opc; op = opv; sh = shv;
        step();
        n = 1;
        while (cur.w !== 1'b1 && n < 12) begin
            if (n - 1 < exp_q.size()) chk({tag, " phase"}, cur, exp_q[n-1]);
            else                      chk({tag, " overrun"}, cur, idle_v);
            s      = 1'($urandom_range(0, 1));
            opcode = 3'($urandom);
            op     = 2'($urandom);
            sh     = 2'($urandom);
            step();
            n++;
        end
        chk_int({tag, " latency"}, n, lat_of(k));
        chk({tag, " done"}, cur, idle_v);
        s = 1'b0;
    endtask

    task automatic idle_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            s = 1'b0; opcode = 3'($urandom); op = 2'($urandom); sh = 2'($urandom);
            step();
            chk("idle", cur, idle_v);
        end
    endtask

    initial begin
        vec_t v;
        idle_v   = '0;
        idle_v.w = 1'b1;
        reset_n = 1'b0; s = 1'b0; opcode = 3'b000; op = 2'b00; sh = 2'b00;
        step();
        step();
        chk("reset state", cur, idle_v);
        reset_n = 1'b1;
        idle_cycles(2);

        // Directed instructions, back to back where possible.
        run_instr(3'b110, 2'b10, 2'b00, "movi");
        run_instr(3'b101, 2'b00, 2'b01, "add");
        run_instr(3'b101, 2'b01, 2'b11, "cmp");
        run_instr(3'b110, 2'b00, 2'b10, "movr");
        run_instr(3'b111, 2'b00, 2'b00, "illegal111");
        run_instr(3'b110, 2'b01, 2'b01, "illegal110_01");
        run_instr(3'b101, 2'b11, 2'b11, "mvn");
        run_instr(3'b101, 2'b10, 2'b10, "and");
        idle_cycles(2);

        // Reset during GET_B of an ADD.
        s = 1'b1; opcode = 3'b101; op = 2'b00; sh = 2'b01;
        step();
        v = '0;
        chk("rst decode", cur, v);
        s = 1'b0;
        step();
        v = '0; v.nsel = 3'b001; v.loada = 1'b1;
        chk("rst get_a", cur, v);
        s = 1'b1;
        step();
        v = '0; v.nsel = 3'b100; v.loadb = 1'b1;
        chk("rst get_b", cur, v);
        reset_n = 1'b0;
        step();
        chk("rst mid", cur, idle_v);
        reset_n = 1'b1;
        idle_cycles(6);

        // Randomized instruction stream.
        for (int i = 0; i < 60; i++) begin
            logic [2:0] ropc;
            logic [1:0] rop;
            int         pick;
            pick = int'($urandom_range(0, 7));
            case (pick)
                0: begin ropc = 3'b110; rop = 2'b10; end
                1: begin ropc = 3'b110; rop = 2'b00; end
                2: begin ropc = 3'b101; rop = 2'b11; end
                3: begin ropc = 3'b101; rop = 2'b00; end
                4: begin ropc = 3'b101; rop = 2'b01; end
                5: begin ropc = 3'b101; rop = 2'b10; end
                default: begin ropc = 3'($urandom); rop = 2'($urandom); end
            endcase
            run_instr(ropc, rop, 2'($urandom), "rand");
            idle_cycles(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
